// File: rtl/lif_pkg.sv
// -----------------------------------------------------------------------------
// lif_pkg
// Types and constants shared by the LIF neuron and its synaptic input stage.
//   WIDTH         : current bus width (matches the lif `current` input)
//   current_t     : current bus type
//   CUR_MAX       : saturation value of the current register
//   decay_shift_t : decay-rate control type
// -----------------------------------------------------------------------------
package lif_pkg;

    localparam int WIDTH = 8;

    typedef logic [WIDTH-1:0] current_t;
    typedef logic [2:0]       decay_shift_t;

    localparam current_t CUR_MAX = '1;

endpackage

// File: rtl/spike_delay_line.sv
// -----------------------------------------------------------------------------
// spike_delay_line
// Axonal delay for a single-bit spike train: a DEPTH-flop shift register.
// DEPTH=0 degenerates to a plain wire.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset, clears all in-flight spikes
//   d_in   : spike sampled every clock
//   d_out  : spike delayed by DEPTH clocks
// -----------------------------------------------------------------------------
module spike_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic d_out
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign d_out = d_in;
        end else begin : g_shift
            logic [DEPTH-1:0] r_sr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sr <= '0;
                end else begin
                    r_sr[0] <= d_in;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_sr[i] <= r_sr[i-1];
                    end
                end
            end

            assign d_out = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/lif_synapse.sv
// -----------------------------------------------------------------------------
// lif_synapse
// Synaptic input stage feeding a lif neuron. Each presynaptic spike is delayed
// by DELAY clocks, then adds the weight register into a saturating current
// register that decays geometrically every clock.
// Optional build macro: SYN_INHIBIT_EN adds an inhibitory spike input with
// its own delay line; a delayed inhibitory spike subtracts the weight (floored
// at 0), and coincident excitatory/inhibitory spikes cancel.
// Ports:
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   spike_in     : presynaptic spike, one spike per high cycle
//   spike_inh    : inhibitory spike (SYN_INHIBIT_EN builds only)
//   weight_wr    : weight load strobe
//   weight_in    : new weight, captured when weight_wr=1
//   decay_shift  : per-cycle loss is cur>>decay_shift, 0 holds the current
//   current_out  : synaptic current to lif.current
//   active       : current_out != 0
//   sat_pulse    : this edge's update clipped at the maximum
// -----------------------------------------------------------------------------
module lif_synapse
    import lif_pkg::*;
#(
    parameter int               WIDTH        = lif_pkg::WIDTH,
    parameter logic [WIDTH-1:0] WEIGHT_RESET = 8'd32,
    parameter int               DELAY        = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spike_in,
`ifdef SYN_INHIBIT_EN
    input  logic             spike_inh,
`endif
    input  logic             weight_wr,
    input  logic [WIDTH-1:0] weight_in,
    input  decay_shift_t     decay_shift,
    output logic [WIDTH-1:0] current_out,
    output logic             active,
    output logic             sat_pulse
);

    localparam logic [WIDTH-1:0] L_MAX = '1;
    localparam logic [WIDTH-1:0] L_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] r_weight;
    logic             r_sat;

    logic             w_exc;
    logic             w_inh;
    logic             w_add;
    logic             w_sub;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_next;
    logic             w_clip;

    spike_delay_line #(.DEPTH(DELAY)) u_exc_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (spike_in),
        .d_out (w_exc)
    );

`ifdef SYN_INHIBIT_EN
    spike_delay_line #(.DEPTH(DELAY)) u_inh_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (spike_inh),
        .d_out (w_inh)
    );
`else
    assign w_inh = 1'b0;
`endif

    // Coincident excitatory and inhibitory spikes cancel out.
    assign w_add = w_exc & ~w_inh;
    assign w_sub = w_inh & ~w_exc;

    // A nonzero current always loses at least 1 when decay is enabled, so
    // small residues cannot get stuck above zero.
    always_comb begin
        w_dec = '0;
        if (decay_shift != '0) begin
            w_dec = r_cur >> decay_shift;
            if (w_dec == '0 && r_cur != '0) begin
                w_dec = L_ONE;
            end
        end
    end

    // w_dec never exceeds r_cur, so w_base cannot wrap.
    assign w_base = r_cur - w_dec;
    assign w_sum  = {1'b0, w_base} + (w_add ? {1'b0, r_weight} : {(WIDTH+1){1'b0}});

    always_comb begin
        w_next = w_sum[WIDTH-1:0];
        w_clip = 1'b0;
        if (w_sum[WIDTH]) begin
            w_next = L_MAX;
            w_clip = 1'b1;
        end else if (w_sub) begin
            // Flooring at zero is not a saturation event.
            w_next = (r_weight > w_base) ? '0 : (w_base - r_weight);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur    <= '0;
            r_sat    <= 1'b0;
            r_weight <= WEIGHT_RESET;
        end else begin
            r_cur <= w_next;
            r_sat <= w_clip;
            // The update above already used the old weight this cycle.
            if (weight_wr) begin
                r_weight <= weight_in;
            end
        end
    end

    assign current_out = r_cur;
    assign active      = (r_cur != '0);
    assign sat_pulse   = r_sat;

endmodule

// File: tb/tb_lif_synapse.sv
module tb_lif_synapse;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spike_in = 1'b0;
    logic       spike_inh = 1'b0;
    logic       weight_wr = 1'b0;
    logic [7:0] weight_in = 8'd0;
    logic [2:0] decay_shift = 3'd0;

    logic [7:0] cur_o [3];
    logic       act_o [3];
    logic       sat_o [3];

    int checks = 0;
    int errors = 0;

    // Reference model: spike history since reset, plus expected current/sat.
    bit hist_exc [$];
    bit hist_inh [$];
    int m_cur [3];
    int m_sat [3];
    int m_w;

    always #5 clk = ~clk;

    lif_synapse #(.DELAY(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .spike_in(spike_in),
`ifdef SYN_INHIBIT_EN
        .spike_inh(spike_inh),
`endif
        .weight_wr(weight_wr), .weight_in(weight_in), .decay_shift(decay_shift),
        .current_out(cur_o[0]), .active(act_o[0]), .sat_pulse(sat_o[0]));

    lif_synapse #(.DELAY(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .spike_in(spike_in),
`ifdef SYN_INHIBIT_EN
        .spike_inh(spike_inh),
`endif
        .weight_wr(weight_wr), .weight_in(weight_in), .decay_shift(decay_shift),
        .current_out(cur_o[1]), .active(act_o[1]), .sat_pulse(sat_o[1]));

    lif_synapse #(.DELAY(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .spike_in(spike_in),
`ifdef SYN_INHIBIT_EN
        .spike_inh(spike_inh),
`endif
        .weight_wr(weight_wr), .weight_in(weight_in), .decay_shift(decay_shift),
        .current_out(cur_o[2]), .active(act_o[2]), .sat_pulse(sat_o[2]));

    function automatic int dly(int j);
        case (j)
            0: return 0;
            1: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic void model_reset();
        hist_exc.delete();
        hist_inh.delete();
        for (int j = 0; j < 3; j++) begin
            m_cur[j] = 0;
            m_sat[j] = 0;
        end
        m_w = 32;
    endfunction

    // One clock edge of the behavioural rules, applied to all three delays.
    function automatic void model_edge();
        int idx, d, s;
        bit exc, inh;
        hist_exc.push_back(spike_in);
`ifdef SYN_INHIBIT_EN
        hist_inh.push_back(spike_inh);
`else
        hist_inh.push_back(1'b0);
`endif
        idx = hist_exc.size() - 1;
        for (int j = 0; j < 3; j++) begin
            exc = (idx >= dly(j)) ? hist_exc[idx - dly(j)] : 1'b0;
            inh = (idx >= dly(j)) ? hist_inh[idx - dly(j)] : 1'b0;
            d = 0;
            if (decay_shift != 0) begin
                d = m_cur[j] >> decay_shift;
                if (d == 0 && m_cur[j] != 0) d = 1;
            end
            s = m_cur[j] - d;
            if (exc && !inh) s = s + m_w;
            if (inh && !exc) s = s - m_w;
            m_sat[j] = (s > 255) ? 1 : 0;
            if (s > 255) s = 255;
            if (s < 0) s = 0;
            m_cur[j] = s;
        end
        if (weight_wr) m_w = weight_in;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        spike_in = 1'b0;
        spike_inh = 1'b0;
        weight_wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (cur_o[j] !== 8'd0 || act_o[j] !== 1'b0 || sat_o[j] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d: cur=%0d act=%b sat=%b, required 0/0/0",
                         j, cur_o[j], act_o[j], sat_o[j]);
            end
        end
    endtask

    task automatic test_decay_trajectory();
        int exp_seq [14] = '{32, 24, 18, 14, 11, 9, 7, 6, 5, 4, 3, 2, 1, 0};
        do_reset();
        decay_shift = 3'd2;
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        checks++;
        if (cur_o[1] !== 8'd0) begin
            errors++;
            $display("FAIL decay_edge0: cur=%0d, required 0", cur_o[1]);
        end
        tick();
        checks++;
        if (cur_o[1] !== 8'd0) begin
            errors++;
            $display("FAIL decay_edge1: cur=%0d, required 0", cur_o[1]);
        end
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if (cur_o[1] !== exp_seq[i][7:0] || act_o[1] !== (exp_seq[i] != 0)) begin
                errors++;
                $display("FAIL decay_seq[%0d]: cur=%0d act=%b, required %0d act=%b",
                         i, cur_o[1], act_o[1], exp_seq[i], exp_seq[i] != 0);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        decay_shift = 3'd0;
        weight_wr = 1'b1;
        weight_in = 8'd200;
        tick();
        weight_wr = 1'b0;
        spike_in = 1'b1;
        tick();
        checks++;
        if (cur_o[0] !== 8'd200 || sat_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL sat_first: cur=%0d sat=%b, required 200/0", cur_o[0], sat_o[0]);
        end
        tick();
        spike_in = 1'b0;
        checks++;
        if (cur_o[0] !== 8'd255 || sat_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL sat_clip: cur=%0d sat=%b, required 255/1", cur_o[0], sat_o[0]);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (cur_o[0] !== 8'd255 || sat_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL sat_hold[%0d]: cur=%0d sat=%b, required 255/0", i, cur_o[0], sat_o[0]);
            end
        end
    endtask

    task automatic test_weight_collision();
        do_reset();
        decay_shift = 3'd0;
        spike_in = 1'b1;
        weight_wr = 1'b1;
        weight_in = 8'd100;
        tick();
        weight_wr = 1'b0;
        checks++;
        if (cur_o[0] !== 8'd32) begin
            errors++;
            $display("FAIL wr_collision_old: cur=%0d, required 32", cur_o[0]);
        end
        tick();
        spike_in = 1'b0;
        checks++;
        if (cur_o[0] !== 8'd132) begin
            errors++;
            $display("FAIL wr_collision_new: cur=%0d, required 132", cur_o[0]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        decay_shift = 3'd0;
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        tick();
        checks++;
        if (cur_o[0] !== 8'd32 || cur_o[2] !== 8'd0) begin
            errors++;
            $display("FAIL arst_pre: d0=%0d d3=%0d, required 32/0", cur_o[0], cur_o[2]);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (cur_o[0] !== 8'd0 || act_o[0] !== 1'b0 || sat_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate: cur=%0d act=%b sat=%b, required 0/0/0",
                     cur_o[0], act_o[0], sat_o[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (cur_o[2] !== 8'd0) begin
            errors++;
            $display("FAIL arst_flushed: cur=%0d, required 0", cur_o[2]);
        end
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (cur_o[2] !== 8'd32) begin
            errors++;
            $display("FAIL arst_weight: cur=%0d, required 32", cur_o[2]);
        end
    endtask

    task automatic test_hold();
        do_reset();
        decay_shift = 3'd0;
        weight_wr = 1'b1;
        weight_in = 8'd50;
        tick();
        weight_wr = 1'b0;
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (cur_o[0] !== 8'd50) begin
                errors++;
                $display("FAIL hold[%0d]: cur=%0d, required 50", i, cur_o[0]);
            end
        end
        decay_shift = 3'd1;
        tick();
        checks++;
        if (cur_o[0] !== 8'd25) begin
            errors++;
            $display("FAIL hold_release: cur=%0d, required 25", cur_o[0]);
        end
    endtask

`ifdef SYN_INHIBIT_EN
    task automatic test_inhibit();
        do_reset();
        decay_shift = 3'd0;
        weight_wr = 1'b1;
        weight_in = 8'd40;
        tick();
        weight_in = 8'd32;
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        weight_wr = 1'b0;
        decay_shift = 3'd2;
        spike_inh = 1'b1;
        tick();
        spike_inh = 1'b0;
        checks++;
        if (cur_o[0] !== 8'd0 || sat_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL inh_floor: cur=%0d sat=%b, required 0/0", cur_o[0], sat_o[0]);
        end
        decay_shift = 3'd0;
        weight_wr = 1'b1;
        weight_in = 8'd40;
        tick();
        weight_wr = 1'b0;
        spike_in = 1'b1;
        tick();
        decay_shift = 3'd2;
        spike_inh = 1'b1;
        tick();
        spike_in = 1'b0;
        spike_inh = 1'b0;
        checks++;
        if (cur_o[0] !== 8'd30) begin
            errors++;
            $display("FAIL inh_cancel: cur=%0d, required 30", cur_o[0]);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (n % 200 == 199) do_reset();
            spike_in    = ($urandom_range(0, 2) == 0);
`ifdef SYN_INHIBIT_EN
            spike_inh   = ($urandom_range(0, 4) == 0);
`endif
            weight_wr   = ($urandom_range(0, 9) == 0);
            weight_in   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) decay_shift = 3'($urandom_range(0, 7));
            tick();
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (cur_o[j] !== m_cur[j][7:0] || sat_o[j] !== m_sat[j][0] ||
                    act_o[j] !== (m_cur[j] != 0)) begin
                    errors++;
                    $display("FAIL random[%0d] dut%0d: cur=%0d sat=%b act=%b, required %0d/%0d/%0d",
                             n, j, cur_o[j], sat_o[j], act_o[j], m_cur[j], m_sat[j], m_cur[j] != 0);
                end
            end
        end
        spike_in = 1'b0;
        spike_inh = 1'b0;
        weight_wr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_decay_trajectory();
        test_saturation();
        test_weight_collision();
        test_async_reset();
        test_hold();
`ifdef SYN_INHIBIT_EN
        test_inhibit();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
